// File: rtl/dcache_ctrl_if.sv
// CPU-side and memory-side signal bundle for the direct-mapped data cache.
// slave = the cache itself, master = the pipeline/memory environment.
interface dcache_ctrl_if;
   logic         cpu_req_i;
   logic         cpu_we_i;
   logic [31:0]  cpu_addr_i;
   logic [31:0]  cpu_data_i;
   logic [31:0]  cpu_data_o;
   logic         cpu_stall_o;
   logic         mem_req_o;
   logic         mem_we_o;
   logic [31:0]  mem_addr_o;
   logic [127:0] mem_data_o;
   logic [127:0] mem_data_i;
   logic         mem_ack_i;

   modport slave (
      input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
   );

   modport master (
      output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
      input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
   );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache between MEM stage and line-wide memory.
//
// state       | meaning
// S_IDLE      | serve hits combinationally; detect misses
// S_WRITEBACK | write dirty victim line to memory, wait for ack
// S_ALLOCATE  | read missing line from memory, wait for ack, install it
module dcache_ctrl #(
   parameter int NUM_LINES = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   dcache_ctrl_if.slave bus
);
   localparam int IW = $clog2(NUM_LINES);
   localparam int TW = 32 - IW - 4;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

   state_t                r_state;
   state_t                w_next;
   logic [NUM_LINES-1:0]  r_valid;
   logic [NUM_LINES-1:0]  r_dirty;
   logic [TW-1:0]         r_tag  [NUM_LINES];
   logic [31:0]           r_data [NUM_LINES][4];
   logic [27:0]           r_line_addr;

   logic [IW-1:0] w_idx;
   logic [TW-1:0] w_tag;
   logic [1:0]    w_off;
   logic [IW-1:0] w_miss_idx;
   logic          w_hit;
   logic          w_fill;
   logic          w_unused_bits;

   assign w_idx         = bus.cpu_addr_i[IW+3:4];
   assign w_tag         = bus.cpu_addr_i[31:IW+4];
   assign w_off         = bus.cpu_addr_i[3:2];
   assign w_unused_bits = ^bus.cpu_addr_i[1:0];
   // Transfers use the address captured at miss time so a dropped request cannot corrupt them.
   assign w_miss_idx    = r_line_addr[IW-1:0];

   assign w_hit  = bus.cpu_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & (r_state == S_IDLE);
   assign w_fill = (r_state == S_ALLOCATE) & bus.mem_ack_i;

   assign bus.cpu_stall_o = bus.cpu_req_i & ~w_hit;
   assign bus.cpu_data_o  = r_data[w_idx][w_off];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:
            if (bus.cpu_req_i && !w_hit)
               w_next = (r_valid[w_idx] && r_dirty[w_idx]) ? S_WRITEBACK : S_ALLOCATE;
         S_WRITEBACK:
            if (bus.mem_ack_i) w_next = S_ALLOCATE;
         S_ALLOCATE:
            if (bus.mem_ack_i) w_next = S_IDLE;
         default:
            w_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.mem_req_o  = 1'b0;
      bus.mem_we_o   = 1'b0;
      bus.mem_addr_o = '0;
      bus.mem_data_o = '0;
      case (r_state)
         S_WRITEBACK: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_we_o   = 1'b1;
            bus.mem_addr_o = {r_tag[w_miss_idx], w_miss_idx, 4'b0000};
            bus.mem_data_o = {r_data[w_miss_idx][3], r_data[w_miss_idx][2],
                              r_data[w_miss_idx][1], r_data[w_miss_idx][0]};
         end
         S_ALLOCATE: begin
            bus.mem_req_o  = 1'b1;
            bus.mem_addr_o = {r_line_addr, 4'b0000};
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid     <= '0;
         r_dirty     <= '0;
         r_line_addr <= '0;
      end else begin
         if (r_state == S_IDLE && bus.cpu_req_i && !w_hit)
            r_line_addr <= bus.cpu_addr_i[31:4];
         if (w_fill) begin
            r_valid[w_miss_idx] <= 1'b1;
            r_dirty[w_miss_idx] <= 1'b0;
         end else if (w_hit && bus.cpu_we_i) begin
            r_dirty[w_idx] <= 1'b1;
         end
      end
   end

   // Tag and data arrays carry no reset; valid bits guard them.
   always_ff @(posedge clk_i) begin
      if (w_fill) begin
         r_tag[w_miss_idx]     <= r_line_addr[27:IW];
         r_data[w_miss_idx][0] <= bus.mem_data_i[31:0];
         r_data[w_miss_idx][1] <= bus.mem_data_i[63:32];
         r_data[w_miss_idx][2] <= bus.mem_data_i[95:64];
         r_data[w_miss_idx][3] <= bus.mem_data_i[127:96];
      end else if (w_hit && bus.cpu_we_i) begin
         r_data[w_idx][w_off] <= bus.cpu_data_i;
      end
   end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: hits, clean/dirty misses, delayed ack, reset mid-refill.
module tb_dcache_ctrl;
   logic clk_i = 1'b0;
   logic rst_i;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_stall;

   dcache_ctrl_if bus ();

   dcache_ctrl #(.NUM_LINES(32)) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .bus   (bus)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      @(negedge clk_i);
   endtask

   task automatic cpu(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] data);
      bus.cpu_req_i  = req;
      bus.cpu_we_i   = we;
      bus.cpu_addr_i = addr;
      bus.cpu_data_i = data;
      #1;
   endtask

   task automatic ack(input logic a, input logic [127:0] line);
      bus.mem_ack_i  = a;
      bus.mem_data_i = line;
      #1;
   endtask

   initial begin
      rst_i = 1'b0;
      cpu(1'b0, 1'b0, 32'h0, 32'h0);
      ack(1'b0, '0);
      tick();
      tick();
      chk("rst_mem_req", bus.mem_req_o, 1'b0);
      chk("rst_mem_we", bus.mem_we_o, 1'b0);
      chk("rst_stall_idle", bus.cpu_stall_o, 1'b0);
      cpu(1'b1, 1'b0, 32'h4, 32'h0);
      chk("rst_stall_follows_req", bus.cpu_stall_o, 1'b1);

      // clean miss, L=0
      rst_i = 1'b1;
      #1;
      chk("m1_c0_stall", bus.cpu_stall_o, 1'b1);
      chk("m1_c0_no_req", bus.mem_req_o, 1'b0);
      tick();
      chk("m1_alloc_req", bus.mem_req_o, 1'b1);
      chk("m1_alloc_we", bus.mem_we_o, 1'b0);
      chk("m1_alloc_addr", bus.mem_addr_o, 32'h0);
      chk("m1_c1_stall", bus.cpu_stall_o, 1'b1);
      ack(1'b1, {32'h4, 32'h3, 32'h2, 32'h1});
      tick();
      ack(1'b0, '0);
      chk("m1_c2_stall", bus.cpu_stall_o, 1'b0);
      chk("m1_data", bus.cpu_data_o, 32'h2);
      chk("m1_idle_req", bus.mem_req_o, 1'b0);

      // store hit then reload
      cpu(1'b1, 1'b1, 32'h4, 32'hDEADBEEF);
      chk("sh_stall", bus.cpu_stall_o, 1'b0);
      tick();
      cpu(1'b1, 1'b0, 32'h4, 32'h0);
      chk("sh_reload", bus.cpu_data_o, 32'hDEADBEEF);
      cpu(1'b1, 1'b0, 32'h0, 32'h0);
      chk("sh_word0_kept", bus.cpu_data_o, 32'h1);

      // dirty miss on index 0
      cpu(1'b1, 1'b0, 32'h204, 32'h0);
      chk("dm_stall", bus.cpu_stall_o, 1'b1);
      tick();
      chk("dm_wb_req", bus.mem_req_o, 1'b1);
      chk("dm_wb_we", bus.mem_we_o, 1'b1);
      chk("dm_wb_addr", bus.mem_addr_o, 32'h0);
      chk("dm_wb_word1", bus.mem_data_o[63:32], 32'hDEADBEEF);
      chk("dm_wb_line", bus.mem_data_o, {32'h4, 32'h3, 32'hDEADBEEF, 32'h1});
      ack(1'b1, '0);
      tick();
      ack(1'b0, '0);
      chk("dm_alloc_we", bus.mem_we_o, 1'b0);
      chk("dm_alloc_addr", bus.mem_addr_o, 32'h200);
      chk("dm_alloc_stall", bus.cpu_stall_o, 1'b1);
      ack(1'b1, {32'h8, 32'h7, 32'h6, 32'h5});
      tick();
      ack(1'b0, '0);
      chk("dm_hit_stall", bus.cpu_stall_o, 1'b0);
      chk("dm_data", bus.cpu_data_o, 32'h6);

      // store miss to clean line: refill then merge
      cpu(1'b1, 1'b1, 32'h18, 32'hCAFEF00D);
      chk("sm_stall", bus.cpu_stall_o, 1'b1);
      tick();
      chk("sm_alloc_addr", bus.mem_addr_o, 32'h10);
      chk("sm_alloc_we", bus.mem_we_o, 1'b0);
      ack(1'b1, {32'hD, 32'hC, 32'hB, 32'hA});
      tick();
      ack(1'b0, '0);
      chk("sm_hit_stall", bus.cpu_stall_o, 1'b0);
      tick();
      cpu(1'b1, 1'b0, 32'h18, 32'h0);
      chk("sm_word2", bus.cpu_data_o, 32'hCAFEF00D);
      cpu(1'b1, 1'b0, 32'h10, 32'h0);
      chk("sm_word0", bus.cpu_data_o, 32'hA);
      cpu(1'b1, 1'b0, 32'h1C, 32'h0);
      chk("sm_word3", bus.cpu_data_o, 32'hD);
      cpu(1'b1, 1'b0, 32'h218, 32'h0);
      chk("sm_evict_stall", bus.cpu_stall_o, 1'b1);
      tick();
      chk("sm_wb_we", bus.mem_we_o, 1'b1);
      chk("sm_wb_addr", bus.mem_addr_o, 32'h10);
      chk("sm_wb_line", bus.mem_data_o, {32'hD, 32'hCAFEF00D, 32'hB, 32'hA});
      ack(1'b1, '0);
      tick();
      ack(1'b0, '0);
      chk("sm2_alloc_addr", bus.mem_addr_o, 32'h210);
      ack(1'b1, {32'h44, 32'h33, 32'h22, 32'h11});
      tick();
      ack(1'b0, '0);
      chk("sm2_data", bus.cpu_data_o, 32'h33);

      // stray ack in IDLE is ignored
      cpu(1'b0, 1'b0, 32'h0, 32'h0);
      ack(1'b1, {4{32'hFFFFFFFF}});
      chk("stray_no_req", bus.mem_req_o, 1'b0);
      tick();
      ack(1'b0, '0);
      chk("stray_still_idle", bus.mem_req_o, 1'b0);
      cpu(1'b1, 1'b0, 32'h218, 32'h0);
      chk("stray_hit", bus.cpu_stall_o, 1'b0);
      chk("stray_data", bus.cpu_data_o, 32'h33);

      // ack held off 5 cycles in ALLOCATE
      cpu(1'b1, 1'b0, 32'h30, 32'h0);
      n_stall = bus.cpu_stall_o ? 1 : 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.cpu_stall_o) n_stall++;
         chk("hold_req", bus.mem_req_o, 1'b1);
         chk("hold_addr", bus.mem_addr_o, 32'h30);
         if (k == 5) ack(1'b1, {32'h0, 32'h0, 32'h0, 32'h99});
      end
      tick();
      ack(1'b0, '0);
      if (bus.cpu_stall_o) n_stall++;
      chk("hold_stall_cycles", 32'(n_stall), 32'd7);
      chk("hold_data", bus.cpu_data_o, 32'h99);

      // reset during ALLOCATE
      cpu(1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      chk("rr_alloc_req", bus.mem_req_o, 1'b1);
      rst_i = 1'b0;
      #1;
      chk("rr_req_drop", bus.mem_req_o, 1'b0);
      tick();
      rst_i = 1'b1;
      #1;
      chk("rr_miss_again", bus.cpu_stall_o, 1'b1);
      chk("rr_idle_req", bus.mem_req_o, 1'b0);
      tick();
      chk("rr_realloc_we", bus.mem_we_o, 1'b0);
      chk("rr_realloc_addr", bus.mem_addr_o, 32'h40);
      ack(1'b1, {32'h0, 32'h0, 32'h0, 32'h77});
      tick();
      ack(1'b0, '0);
      chk("rr_data", bus.cpu_data_o, 32'h77);
      cpu(1'b1, 1'b0, 32'h4, 32'h0);
      chk("rr_old_line_invalid", bus.cpu_stall_o, 1'b1);
      cpu(1'b0, 1'b0, 32'h0, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-back, write-allocate data cache inserted between the pipeline's MEM stage and the line-wide data memory. It serves MEM-stage loads and stores combinationally on a hit. On a miss it asserts a stall to freeze the pipeline, evicts a dirty victim if needed, refills the line over a req/ack memory handshake, and then completes the access as a hit.

## Interface
- NUM_LINES, 32, number of cache lines; power of two; index width IW = log2(NUM_LINES).
- clk_i  in  1  clock; all state changes on rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- cpu_req_i  in  1  MEM-stage access valid (load or store).
- cpu_we_i  in  1  1 = store (word), 0 = load.
- cpu_addr_i  in  32  byte address; [1:0] ignored, [3:2] word offset, [IW+3:4] index, [31:IW+4] tag.
- cpu_data_i  in  32  store data.
- cpu_data_o  out  32  load data; valid while cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  freeze pipeline; MEM-stage request must be held stable while high.
- mem_req_o  out  1  memory line transfer request.
- mem_we_o  out  1  1 = write-back of victim, 0 = refill read.
- mem_addr_o  out  32  line-aligned address ([3:0]=0).
- mem_data_o  out  128  victim line, word 0 in [31:0].
- mem_data_i  in  128  refill line, word 0 in [31:0].
- mem_ack_i  in  1  one-cycle pulse: transfer done; for reads, mem_data_i is valid in the same cycle.

## Operation
- Storage per line: valid, dirty, tag (32-IW-4 bits), 4x32-bit data.
- hit = cpu_req_i & valid[idx] & (tag[idx] == addr tag) & state==IDLE.
- cpu_stall_o = cpu_req_i & ~hit (combinational).
- Read hit: cpu_data_o = data[idx][offset], combinational, no state change.
- Write hit: at the edge, data[idx][offset] <= cpu_data_i and dirty[idx] <= 1.
- States: IDLE, WRITEBACK, ALLOCATE.
  - IDLE: on cpu_req_i & miss, go to WRITEBACK if valid&dirty of victim, else to ALLOCATE.
  - WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag, idx, 4'b0}, mem_data_o=victim line. On mem_ack_i, go to ALLOCATE.
  - ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={cpu tag, idx, 4'b0}. On mem_ack_i, write the line with mem_data_i and set tag, valid=1, dirty=0; go to IDLE.
- After returning to IDLE the held request hits; a store then merges into the refilled line and sets dirty.
- If cpu_req_i drops mid-miss, the current transfer still completes and the FSM returns to IDLE; no CPU-side write occurs.
- mem_req_o, mem_we_o, mem_addr_o and mem_data_o are decoded from state plus the held address, and stay stable until ack.
- In IDLE, mem_req_o=0, mem_we_o=0, and mem_addr_o/mem_data_o are 0.

## Timing
- Reset (rst_i=0, asynchronous): all valid and dirty bits 0, state IDLE, mem_req_o=0, mem_we_o=0. Data/tag arrays need not be cleared. cpu_stall_o follows cpu_req_i (every access misses).
- Reset mid-transfer: the transfer is abandoned and mem_req_o drops immediately. Memory must discard it.
- Hit: 0 stall cycles.
- Clean miss: the miss is detected in cycle 0, and ALLOCATE runs from cycle 1.
  - If the ack arrives in ALLOCATE cycle 1+L (L ≥ 0 wait cycles), the hit occurs in cycle 2+L, giving 2+L stall cycles.
- Dirty miss: adds 1+Lw stall cycles for WRITEBACK, where Lw is the write-back wait.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- Back-to-back misses to different lines are handled fully serially.

## Test plan
- After reset, load 0x0000_0004 → cpu_stall_o=1 and ALLOCATE with mem_addr_o=0x0000_0000, mem_we_o=0. Ack with line {32'h4,32'h3,32'h2,32'h1} → next cycle stall=0, cpu_data_o=0x2. Total 2 stall cycles with L=0.
- Store 0xDEADBEEF to 0x4 (hit) → 0 stalls, and dirty[0]=1. Load 0x4 → 0xDEADBEEF.
- Load 0x0000_0204 (index 0, new tag) → WRITEBACK with mem_addr_o=0x0, mem_we_o=1, mem_data_o[63:32]=0xDEADBEEF. Then ALLOCATE with addr 0x200. Data is correct after ack.
- Store miss to clean line 0x0000_0018 → ALLOCATE at 0x10; after refill, word 2 is replaced by the store data and dirty=1. The other words match the refill.
- Hold the ack off 5 cycles in ALLOCATE → mem_req_o and mem_addr_o stay stable, and stall lasts 7 cycles.
- Assert rst_i=0 during ALLOCATE → mem_req_o=0 immediately. After release, a load to the same address misses again.
